// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared state encoding and default timing for the reset sequencer
package rst_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } rst_seq_state_t;

    localparam int DEF_LOCK_HOLD = 1000;
    localparam int DEF_STAGE_GAP = 64;

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - N-flop single-bit synchronizer with async clear to 0
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - qualifies PLL lock and releases staged domain resets in order
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_HOLD   = DEF_LOCK_HOLD,
    parameter int STAGE_GAP   = DEF_STAGE_GAP,
    parameter int NUM_STAGES  = 3
) (
    input  logic                  clk_c0,
    input  logic                  rst_n,
    input  logic                  locked,
    input  logic                  sw_rst_req,
    output logic [NUM_STAGES-1:0] rst_out_n,
    output logic                  ready,
    output logic [7:0]            lock_loss_cnt
);

    localparam int HW = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD) : 1;
    localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int IW = $clog2(NUM_STAGES + 1);

    localparam logic [HW-1:0] HOLD_LAST = HW'(LOCK_HOLD - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);

    logic locked_s;

    rst_seq_state_t          state, state_nxt;
    logic [HW-1:0]           hold_cnt, hold_nxt;
    logic [GW-1:0]           gap_cnt, gap_nxt;
    logic [IW-1:0]           idx, idx_nxt;
    logic [NUM_STAGES-1:0]   rst_nxt;
    logic                    ready_nxt;
    logic [7:0]              loss_nxt;

    sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk  (clk_c0),
        .rst_n(rst_n),
        .d    (locked),
        .q    (locked_s)
    );

    always_ff @(posedge clk_c0 or negedge rst_n) begin
        if (!rst_n) begin
            state         <= WAIT_LOCK;
            hold_cnt      <= '0;
            gap_cnt       <= '0;
            idx           <= '0;
            rst_out_n     <= '0;
            ready         <= 1'b0;
            lock_loss_cnt <= 8'd0;
        end else begin
            state         <= state_nxt;
            hold_cnt      <= hold_nxt;
            gap_cnt       <= gap_nxt;
            idx           <= idx_nxt;
            rst_out_n     <= rst_nxt;
            ready         <= ready_nxt;
            lock_loss_cnt <= loss_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        gap_nxt   = gap_cnt;
        idx_nxt   = idx;
        rst_nxt   = rst_out_n;
        ready_nxt = ready;
        loss_nxt  = lock_loss_cnt;

        case (state)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_nxt = HOLD;
                    hold_nxt  = '0;
                end
            end

            HOLD: begin
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (sw_rst_req) begin
                    hold_nxt = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    rst_nxt = NUM_STAGES'(1);
                    gap_nxt = '0;
                    idx_nxt = IW'(1);
                    if (NUM_STAGES == 1) begin
                        ready_nxt = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        state_nxt = RELEASE;
                    end
                end else begin
                    hold_nxt = hold_cnt + HW'(1);
                end
            end

            RELEASE, RUN: begin
                // Lock loss takes priority over a software request and is the only path that counts.
                if (!locked_s) begin
                    rst_nxt   = '0;
                    ready_nxt = 1'b0;
                    state_nxt = WAIT_LOCK;
                    if (lock_loss_cnt != 8'hFF) begin
                        loss_nxt = lock_loss_cnt + 8'd1;
                    end
                end else if (sw_rst_req) begin
                    rst_nxt   = '0;
                    ready_nxt = 1'b0;
                    hold_nxt  = '0;
                    state_nxt = HOLD;
                end else if (state == RELEASE) begin
                    if (gap_cnt == GAP_LAST) begin
                        for (int i = 0; i < NUM_STAGES; i++) begin
                            if (idx == IW'(i)) begin
                                rst_nxt[i] = 1'b1;
                            end
                        end
                        gap_nxt = '0;
                        idx_nxt = idx + IW'(1);
                        if (idx == IDX_LAST) begin
                            ready_nxt = 1'b1;
                            state_nxt = RUN;
                        end
                    end else begin
                        gap_nxt = gap_cnt + GW'(1);
                    end
                end
            end

            default: begin
                state_nxt = WAIT_LOCK;
                rst_nxt   = '0;
                ready_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
module tb_reset_sequencer;

    localparam int SYNC_STAGES = 2;
    localparam int LOCK_HOLD   = 8;
    localparam int STAGE_GAP   = 4;
    localparam int NUM_STAGES  = 3;
    localparam int FIRST_REL   = SYNC_STAGES + LOCK_HOLD;

    logic                  clk_c0 = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  locked = 1'b0;
    logic                  sw_rst_req = 1'b0;
    logic [NUM_STAGES-1:0] rst_out_n;
    logic                  ready;
    logic [7:0]            lock_loss_cnt;

    int total = 0;
    int bad = 0;

    reset_sequencer #(
        .SYNC_STAGES(SYNC_STAGES),
        .LOCK_HOLD  (LOCK_HOLD),
        .STAGE_GAP  (STAGE_GAP),
        .NUM_STAGES (NUM_STAGES)
    ) dut (
        .clk_c0       (clk_c0),
        .rst_n        (rst_n),
        .locked       (locked),
        .sw_rst_req   (sw_rst_req),
        .rst_out_n    (rst_out_n),
        .ready        (ready),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk_c0 = ~clk_c0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_c0);
        #1;
    endtask

    function automatic logic [2:0] exp_rst(input int e, input int first);
        if (e >= first + 2 * STAGE_GAP) return 3'b111;
        if (e >= first + STAGE_GAP)     return 3'b011;
        if (e >= first)                 return 3'b001;
        return 3'b000;
    endfunction

    // Caller raises locked just before edge 0; checks every edge through full release.
    task automatic run_seq(input string tag);
        for (int e = 0; e <= FIRST_REL + 2 * STAGE_GAP + 2; e++) begin
            tick();
            chk({tag, "_rst"}, 32'(rst_out_n), 32'(exp_rst(e, FIRST_REL)));
            chk({tag, "_rdy"}, 32'(ready), 32'(e >= FIRST_REL + 2 * STAGE_GAP));
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_out", 32'(rst_out_n), 32'd0);
        chk("rst_rdy", 32'(ready), 32'd0);
        chk("rst_cnt", 32'(lock_loss_cnt), 32'd0);

        // Clean power-up
        rst_n  = 1'b1;
        locked = 1'b1;
        run_seq("pwr");
        chk("pwr_cnt", 32'(lock_loss_cnt), 32'd0);

        // Lock glitch during qualification
        rst_n  = 1'b0;
        locked = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        locked = 1'b1;
        for (int e = 0; e < 5; e++) begin
            tick();
            chk("gl_hi_rst", 32'(rst_out_n), 32'd0);
        end
        locked = 1'b0;
        for (int e = 0; e < 6; e++) begin
            tick();
            chk("gl_lo_rst", 32'(rst_out_n), 32'd0);
        end
        locked = 1'b1;
        run_seq("gl_seq");
        chk("gl_cnt", 32'(lock_loss_cnt), 32'd0);

        // Lock loss in RUN
        locked = 1'b0;
        tick();
        tick();
        chk("ll_e1_rst", 32'(rst_out_n), 32'h7);
        tick();
        chk("ll_rst", 32'(rst_out_n), 32'd0);
        chk("ll_rdy", 32'(ready), 32'd0);
        chk("ll_cnt", 32'(lock_loss_cnt), 32'd1);
        locked = 1'b1;
        run_seq("ll_seq");

        // Software request in RUN
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        chk("sw_rst", 32'(rst_out_n), 32'd0);
        chk("sw_rdy", 32'(ready), 32'd0);
        for (int k = 1; k <= 2 * LOCK_HOLD + 1; k++) begin
            tick();
            chk("sw_seq_rst", 32'(rst_out_n), 32'(exp_rst(k, LOCK_HOLD)));
            chk("sw_seq_rdy", 32'(ready), 32'(k >= 2 * LOCK_HOLD));
        end
        chk("sw_cnt", 32'(lock_loss_cnt), 32'd1);

        // Asynchronous rst_n mid-RELEASE
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        for (int k = 1; k <= LOCK_HOLD + STAGE_GAP + 1; k++) tick();
        chk("ar_pre_rst", 32'(rst_out_n), 32'h3);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_rst", 32'(rst_out_n), 32'd0);
        chk("ar_rdy", 32'(ready), 32'd0);
        chk("ar_cnt", 32'(lock_loss_cnt), 32'd0);
        #1 rst_n = 1'b1;
        run_seq("ar_seq");

        // Lock loss and software request on the same edge
        locked = 1'b0;
        tick();
        tick();
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        chk("sim_rst", 32'(rst_out_n), 32'd0);
        chk("sim_cnt", 32'(lock_loss_cnt), 32'd1);

        // Saturation over 300 loss events
        for (int n = 0; n < 300; n++) begin
            int wait_cyc;
            locked   = 1'b1;
            wait_cyc = 0;
            while (rst_out_n[0] !== 1'b1 && wait_cyc < 40) begin
                tick();
                wait_cyc++;
            end
            if (wait_cyc >= 40) begin
                chk("sat_wait", 32'(rst_out_n[0]), 32'd1);
                break;
            end
            locked = 1'b0;
            for (int k = 0; k < SYNC_STAGES + 1; k++) tick();
            if (n == 252) chk("sat_254", 32'(lock_loss_cnt), 32'd254);
            if (n == 253) chk("sat_255", 32'(lock_loss_cnt), 32'd255);
            if (n == 254) chk("sat_hold", 32'(lock_loss_cnt), 32'd255);
        end
        chk("sat_end", 32'(lock_loss_cnt), 32'd255);
        chk("sat_rst", 32'(rst_out_n), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Consumer-side reset sequencer in the `clk_c0` domain. It takes the raw PLL `locked` flag and a software reset request, qualifies lock stability, and releases per-domain synchronous resets in a fixed staged order: SDRAM controller, then frame buffer, then LCD timing. On loss of lock it re-asserts every reset at once and restarts qualification. It sits between the clock/PLL block and the SDRAM/LCD datapath.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for `locked`; legal values ≥ 2.
- `LOCK_HOLD`, 1000: cycles `locked` must stay high before the first release; ≥ 1.
- `STAGE_GAP`, 64: cycles between successive stage releases; ≥ 1.
- `NUM_STAGES`, 3: number of reset outputs; 1..8.
- `clk_c0` in 1: sequencer clock (LCD pixel clock).
- `rst_n` in 1: asynchronous, active-low reset.
- `locked` in 1: PLL lock, asynchronous to `clk_c0`.
- `sw_rst_req` in 1: single-cycle synchronous request to re-run the sequence.
- `rst_out_n` out NUM_STAGES: active-low stage resets; bit 0 is released first.
- `ready` out 1: high once all stages are released.
- `lock_loss_cnt` out 8: saturating count of lock losses after release.

## Operation
- `rst_n` low: state `WAIT_LOCK`; `rst_out_n` = 0, `ready` = 0, `lock_loss_cnt` = 0; synchronizer flops, `hold_cnt` and `gap_cnt` = 0.
- `locked` passes through `SYNC_STAGES` flops to become `locked_s`.
- `WAIT_LOCK`:
  - `locked_s` = 1 → `HOLD`, `hold_cnt` = 0.
  - `sw_rst_req` is ignored.
- `HOLD`:
  - `locked_s` = 0 → `WAIT_LOCK`.
  - `sw_rst_req` → `hold_cnt` = 0, stay in `HOLD`.
  - `hold_cnt` == LOCK_HOLD-1 → `RELEASE`, set `rst_out_n[0]`, stage index = 1, `gap_cnt` = 0.
  - Otherwise `hold_cnt` increments.
- `RELEASE`:
  - `gap_cnt` == STAGE_GAP-1 → set `rst_out_n[idx]`, `gap_cnt` = 0, idx increments.
  - When the last bit is set, `ready` = 1 on the same edge → `RUN`.
  - NUM_STAGES = 1: the `HOLD` exit sets bit 0 and `ready` together and goes directly to `RUN`.
- `RELEASE`/`RUN` with `locked_s` = 0:
  - Next edge: all `rst_out_n` = 0, `ready` = 0 → `WAIT_LOCK`.
  - `lock_loss_cnt` increments and saturates at 255.
- `RELEASE`/`RUN` with `sw_rst_req` = 1 and `locked_s` = 1:
  - Next edge: all resets asserted, `ready` = 0 → `HOLD`, `hold_cnt` = 0.
  - `lock_loss_cnt` is unchanged.
- Simultaneous lock loss and `sw_rst_req`: lock loss wins and the counter increments.
- A lock drop during `HOLD` does not count as a loss.
- Stage resets are never released out of order and are always asserted together.

## Timing
- All outputs are registered and change only on rising `clk_c0` edges, except for the asynchronous clear by `rst_n`.
- Edge numbering: edge 0 is the first edge at which `locked` is high.
  - `locked_s` rises at edge SYNC_STAGES-1.
  - `HOLD` is entered at edge SYNC_STAGES.
  - `rst_out_n[0]` rises at edge SYNC_STAGES+LOCK_HOLD.
  - `rst_out_n[k]` rises k·STAGE_GAP edges after bit 0.
- `locked` falling edge to all resets asserted: SYNC_STAGES+1 edges.
- `sw_rst_req` to all resets asserted: 1 edge. Re-release follows LOCK_HOLD cycles later.
- Counter widths:
  - `hold_cnt`: clog2(LOCK_HOLD).
  - `gap_cnt`: clog2(STAGE_GAP).
  - idx: clog2(NUM_STAGES+1).
  - No wrap is reachable, because every compare stops the count before it wraps.

## Structure
- Shared package `rst_seq_pkg` holds:
  - The state encoding: `WAIT_LOCK`, `HOLD`, `RELEASE`, `RUN`.
  - The default LOCK_HOLD and STAGE_GAP values, reused by the system top.
- One sub-module, `sync_bit`:
  - Parameterized N-flop synchronizer with async reset to 0.
  - Carries the tool synchronizer attribute so placement keeps the flops adjacent.
- All remaining logic (FSM, counters, output registers) lives in `reset_sequencer`.

## Test plan
Bench parameters: SYNC_STAGES=2, LOCK_HOLD=8, STAGE_GAP=4, NUM_STAGES=3.
- Clean power-up, `locked` rises before edge 0 → `rst_out_n` goes 001 at edge 10, 011 at edge 14, 111 with `ready` = 1 at edge 18; `lock_loss_cnt` = 0.
- `locked` high for 5 cycles, then low, then high again → no release during the glitch; the full sequence restarts from `HOLD`; `lock_loss_cnt` stays 0.
- `locked` falls in `RUN` → `rst_out_n` = 000 and `ready` = 0 three edges later; `lock_loss_cnt` = 1; re-lock gives the full sequence again.
- `sw_rst_req` pulse in `RUN` → resets = 000 on the next edge; bit 0 re-releases 8 edges after that and `ready` returns 8 edges later still; counter unchanged.
- `rst_n` pulsed low mid-`RELEASE` with `rst_out_n` = 011 → all outputs 0 immediately (asynchronous); the sequence restarts once `rst_n` and `locked` are high.
- 300 lock-loss events after release → `lock_loss_cnt` saturates at 255 and holds.
